data_mem_resp: RTL and testbench
================================

# data_mem_resp

Data-memory responder for the pipelined RV32 core's Memory stage. It accepts load and store requests from the M-stage port: address, store data, a write strobe, a read strobe and funct3. Stores are queued in a small store buffer that drains into a word-organised array on idle cycles. Loads return a sign- or zero-extended result in the same cycle, merged with any pending buffered stores. A stall output lets the hazard unit hold the pipeline when the buffer is full.

## Interface
- ADDR_WIDTH, 10, log2 of array depth in 32-bit words (4 KiB default)
- SB_DEPTH, 4, store-buffer entries; power of two, 2..16
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- MemWriteM  in  1  store request this cycle
- MemReadM  in  1  load request this cycle (never asserted together with MemWriteM)
- funct3M  in  3  access size and signedness (RV32I load/store funct3)
- Mem_WrAddr  in  32  byte address; word index is Mem_WrAddr[ADDR_WIDTH+1:2], upper bits ignored (wrap)
- Mem_WrData  in  32  store data, value right-justified
- ReadData  out  32  extended load result, combinational
- mem_stall  out  1  request not accepted this cycle; core must hold M stage
- misalign  out  1  current request is misaligned or has an illegal funct3; combinational
- err_sticky  out  1  set by any misalign, cleared only by reset
- sb_empty  out  1  store buffer empty

## Operation
- funct3 encodings:
  - 000 = SB/LB, 001 = SH/LH, 010 = SW/LW, 100 = LBU, 101 = LHU.
  - 100 and 101 are legal for loads only.
  - Any other code, or a store using 100/101, is illegal.
- Alignment rules:
  - Halfword accesses require addr[0] = 0.
  - Word accesses require addr[1:0] = 00.
  - Violation or illegal funct3 asserts misalign. The store is dropped, the load returns 0, and err_sticky is set on the next edge.
- Store enqueue:
  - Each entry holds {word index, 32-bit lane-shifted data, 4-bit byte enable}.
  - SB writes lane addr[1:0].
  - SH writes lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
- Buffer structure:
  - Circular FIFO with head and tail pointers of log2(SB_DEPTH) bits that wrap modulo SB_DEPTH.
  - A count register of log2(SB_DEPTH)+1 bits distinguishes full from empty.
- Drain:
  - The array has a single port, so at most one access per cycle.
  - The head entry is written to the array (byte-enabled) on any cycle with MemReadM = 0 and no accepted store, i.e. idle or stalled cycles.
- Load read path:
  - The array word is read combinationally.
  - With forwarding enabled, matching buffer entries are then applied oldest to youngest, per byte enable.
  - The addressed byte or halfword is extracted, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- Full buffer plus store:
  - mem_stall = 1 and the store is not accepted.
  - The head entry drains in the same cycle.
  - The store is accepted next cycle, one cycle of stall in total.
- Simultaneous enqueue and drain cannot occur. Count changes by at most 1 per cycle.
- Loads never stall due to a full buffer.
- Array contents are not reset. The buffer is discarded on reset, so pending stores are lost.

## Timing
- Load latency 0: ReadData is valid in the same cycle as MemReadM.
- Store visibility:
  - Enqueued on the rising edge.
  - Visible to loads from the next cycle, via forwarding or after drain.
  - Reaches the array at the earliest on the next idle edge.
- mem_stall and misalign are combinational from the current-cycle inputs and buffer state.
- Reset (asynchronous, while low):
  - head = tail = count = 0, sb_empty = 1, err_sticky = 0, mem_stall = 0.
  - ReadData is forced to 0.
- Reset asserted mid-drain: the in-flight array write for that edge is suppressed.

## Configuration
- DMEM_SB_FWD_EN defined: store-to-load forwarding as described. Loads never stall.
- Undefined, no forwarding:
  - A load whose word index matches any valid buffer entry asserts mem_stall.
  - The buffer drains one entry per stalled cycle until no match remains, then the load completes from the array.
  - Maximum stall is SB_DEPTH cycles.

## Test plan
- Store then load, with DMEM_SB_FWD_EN: SW 0x8000_00F1 @0x10, next cycle LB @0x10 → ReadData 0xFFFF_FFF1, and LBU @0x13 → 0x0000_0080, no stall.
- Byte merge: SW 0x1122_3344 @0x20, SB 0xAA @0x21, then LW @0x20 → 0x1122_AA44, correct before and after drain.
- Buffer full, SB_DEPTH = 4: five back-to-back SW, no idle cycles → mem_stall = 1 on the 5th only for exactly 1 cycle, and all five words read back correctly after drain.
- Misaligned: SH @0x31 → misalign = 1, store dropped, err_sticky = 1 next cycle; LW @0x32 → ReadData 0.
- Without forwarding: SW 0xDEAD_BEEF @0x40 followed immediately by LW @0x40 → mem_stall = 1 for 1 cycle, then ReadData 0xDEAD_BEEF.
- Reset: deassert reset with 3 entries pending → sb_empty = 1, err_sticky = 0, and a load of those addresses returns the pre-store array value.

Source files
------------

// File: rtl/data_mem_resp.sv
// M-stage data memory responder: word array fed by a circular store buffer.
// Optional macro DMEM_SB_FWD_EN enables store-to-load forwarding from the buffer.
module data_mem_resp #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned SB_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        mem_stall,
  output logic        misalign,
  output logic        err_sticky,
  output logic        sb_empty
);

  localparam int unsigned PW    = $clog2(SB_DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem     [DEPTH];
  logic [ADDR_WIDTH-1:0] sb_idx  [SB_DEPTH];
  logic [31:0]           sb_data [SB_DEPTH];
  logic [3:0]            sb_be   [SB_DEPTH];

  logic [PW-1:0]         head, tail, pos;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            ofs;
  logic                  f3_legal, align_ok, sb_full, st_acc, ld_hit, ld_stall, drain;
  logic [31:0]           st_data, merged, rdata;
  logic [3:0]            st_be;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic                  unused_addr;

  assign idx         = Mem_WrAddr[ADDR_WIDTH+1:2];
  assign ofs         = Mem_WrAddr[1:0];
  assign unused_addr = ^Mem_WrAddr[31:ADDR_WIDTH+2];

  // funct3 legality and natural alignment; LBU/LHU codes are load-only
  always_comb begin
    f3_legal = 1'b0;
    align_ok = 1'b0;
    case (funct3M)
      3'b000: begin f3_legal = 1'b1;     align_ok = 1'b1;         end
      3'b001: begin f3_legal = 1'b1;     align_ok = ~ofs[0];      end
      3'b010: begin f3_legal = 1'b1;     align_ok = (ofs == 2'b00); end
      3'b100: begin f3_legal = MemReadM; align_ok = 1'b1;         end
      3'b101: begin f3_legal = MemReadM; align_ok = ~ofs[0];      end
      default: ;
    endcase
  end

  assign misalign = (MemReadM | MemWriteM) & ~(f3_legal & align_ok);
  assign sb_full  = (count == CW'(SB_DEPTH));
  assign sb_empty = (count == '0);
  assign st_acc   = MemWriteM & ~misalign & ~sb_full;
  assign ld_stall = MemReadM & ~misalign & ld_hit;
  assign mem_stall = reset & ((MemWriteM & ~misalign & sb_full) | ld_stall);
  // Single-ported array: drain only when no load uses it (or the load is waiting on the buffer)
  assign drain    = ~sb_empty & ~st_acc & (~MemReadM | ld_stall);

  always_comb begin
    st_data = Mem_WrData;
    st_be   = 4'b1111;
    case (funct3M[1:0])
      2'b00: begin
        st_data = {24'b0, Mem_WrData[7:0]} << {ofs, 3'b000};
        st_be   = 4'b0001 << ofs;
      end
      2'b01: begin
        st_data = ofs[1] ? {Mem_WrData[15:0], 16'b0} : {16'b0, Mem_WrData[15:0]};
        st_be   = ofs[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Array word overlaid with pending stores, oldest first so the youngest wins
  always_comb begin
    merged = mem[idx];
    ld_hit = 1'b0;
    pos    = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      pos = head + PW'(i);
      if ((CW'(i) < count) && (sb_idx[pos] == idx)) begin
`ifdef DMEM_SB_FWD_EN
        for (int b = 0; b < 4; b++) begin
          if (sb_be[pos][b]) merged[8*b +: 8] = sb_data[pos][8*b +: 8];
        end
`else
        ld_hit = 1'b1;
`endif
      end
    end
  end

  assign byte_sel = merged[{ofs, 3'b000} +: 8];
  assign half_sel = ofs[1] ? merged[31:16] : merged[15:0];

  always_comb begin
    rdata = '0;
    case (funct3M)
      3'b000:  rdata = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  rdata = {{16{half_sel[15]}}, half_sel};
      3'b010:  rdata = merged;
      3'b100:  rdata = {24'b0, byte_sel};
      3'b101:  rdata = {16'b0, half_sel};
      default: rdata = '0;
    endcase
  end

  assign ReadData = (reset && MemReadM && !misalign) ? rdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (misalign) err_sticky <= 1'b1;
      if (st_acc) begin
        tail  <= tail + PW'(1);
        count <= count + CW'(1);
      end else if (drain) begin
        head  <= head + PW'(1);
        count <= count - CW'(1);
      end
    end
  end

  // Buffer payload and array contents carry no reset
  always_ff @(posedge clk) begin
    if (st_acc) begin
      sb_idx[tail]  <= idx;
      sb_data[tail] <= st_data;
      sb_be[tail]   <= st_be;
    end
  end

  always_ff @(posedge clk) begin
    if (drain && reset) begin
      for (int b = 0; b < 4; b++) begin
        if (sb_be[head][b]) mem[sb_idx[head]][8*b +: 8] <= sb_data[head][8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp; stall expectations follow DMEM_SB_FWD_EN.
module tb_data_mem_resp;

  logic        clk;
  logic        reset;
  logic        MemWriteM;
  logic        MemReadM;
  logic [2:0]  funct3M;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [31:0] ReadData;
  logic        mem_stall;
  logic        misalign;
  logic        err_sticky;
  logic        sb_empty;

`ifdef DMEM_SB_FWD_EN
  localparam int unsigned HIT_STALL = 0;
`else
  localparam int unsigned HIT_STALL = 1;
`endif

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [0:1023];
  int          s;
  logic [2:0]  f3tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  data_mem_resp dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .funct3M    (funct3M),
    .Mem_WrAddr (Mem_WrAddr),
    .Mem_WrData (Mem_WrData),
    .ReadData   (ReadData),
    .mem_stall  (mem_stall),
    .misalign   (misalign),
    .err_sticky (err_sticky),
    .sb_empty   (sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Program-order byte memory model
  function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   ref_mem[a[11:2]][8*a[1:0] +: 8] = d[7:0];
      2'b01:   ref_mem[a[11:2]][16*a[1] +: 16] = d[15:0];
      default: ref_mem[a[11:2]] = d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = ref_mem[a[11:2]];
    b = w[8*a[1:0] +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return 32'b0;
    endcase
  endfunction

  task automatic idle(input int n);
    MemWriteM = 1'b0;
    MemReadM  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                          output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    MemWriteM = 1'b1; MemReadM = 1'b0;
    Mem_WrAddr = a; Mem_WrData = d; funct3M = f3;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (mem_stall) stalls++;
      else done = 1'b1;
      @(posedge clk);
      #1;
    end
    check_eq("st_accept", 32'(done), 32'd1);
    model_store(a, d, f3);
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] exp, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    exp_q.push_back(exp);
    MemReadM = 1'b1; MemWriteM = 1'b0;
    Mem_WrAddr = a; funct3M = f3;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (mem_stall) stalls++;
      else begin
        done = 1'b1;
        check_eq(tag, ReadData, exp_q.pop_front());
      end
      @(posedge clk);
      #1;
    end
    check_eq("ld_accept", 32'(done), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    int          sz;
    logic [2:0]  f3;

    reset = 1'b0; MemWriteM = 1'b0; MemReadM = 1'b1;
    funct3M = 3'b010; Mem_WrAddr = 32'h0; Mem_WrData = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_sb_empty", 32'(sb_empty), 32'd1);
    check_eq("rst_err", 32'(err_sticky), 32'd0);
    check_eq("rst_stall", 32'(mem_stall), 32'd0);
    check_eq("rst_rdata", ReadData, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; MemReadM = 1'b0;
    idle(1);

    // Store then immediate sign/zero-extended loads
    do_store(32'h10, 32'h8000_00F1, 3'b010, s);
    do_load("lb_after_sw", 32'h10, 3'b000, 32'hFFFF_FFF1, s);
    check_eq("lb_stall", 32'(s), 32'(HIT_STALL));
    do_load("lbu_byte3", 32'h13, 3'b100, 32'h0000_0080, s);
    check_eq("lbu_stall", 32'(s), 32'd0);
    idle(8);

    // Byte merge over a word, before and after drain
    do_store(32'h20, 32'h1122_3344, 3'b010, s);
    do_store(32'h21, 32'h0000_00AA, 3'b000, s);
    do_load("merge_pend", 32'h20, 3'b010, 32'h1122_AA44, s);
    idle(8);
    check_eq("merge_drained", 32'(sb_empty), 32'd1);
    do_load("merge_arr", 32'h20, 3'b010, 32'h1122_AA44, s);
    do_load("lh_merge", 32'h20, 3'b001, 32'hFFFF_AA44, s);

    // Five back-to-back stores into a 4-deep buffer
    for (int k = 0; k < 5; k++) begin
      do_store(32'h50 + 32'(4*k), 32'hC0DE_0000 + 32'(k), 3'b010, s);
      check_eq($sformatf("full_stall%0d", k), 32'(s), (k == 4) ? 32'd1 : 32'd0);
    end
    idle(8);
    for (int k = 0; k < 5; k++)
      do_load($sformatf("full_rd%0d", k), 32'h50 + 32'(4*k), 3'b010, 32'hC0DE_0000 + 32'(k), s);

    // Misaligned halfword store is dropped and latches the sticky error
    do_store(32'h30, 32'h5555_AAAA, 3'b010, s);
    idle(6);
    MemWriteM = 1'b1; Mem_WrAddr = 32'h31; Mem_WrData = 32'h0000_1234; funct3M = 3'b001;
    @(negedge clk);
    check_eq("sh_misalign", 32'(misalign), 32'd1);
    check_eq("sh_no_stall", 32'(mem_stall), 32'd0);
    check_eq("err_before", 32'(err_sticky), 32'd0);
    @(posedge clk); #1;
    MemWriteM = 1'b0;
    check_eq("err_after", 32'(err_sticky), 32'd1);
    MemWriteM = 1'b1; Mem_WrAddr = 32'h34; funct3M = 3'b100;
    @(negedge clk);
    check_eq("sbu_illegal", 32'(misalign), 32'd1);
    @(posedge clk); #1;
    idle(4);
    check_eq("drop_empty", 32'(sb_empty), 32'd1);
    do_load("drop_keep", 32'h30, 3'b010, 32'h5555_AAAA, s);
    do_load("lw_misal", 32'h32, 3'b010, 32'h0, s);
    do_load("ld_f3_011", 32'h30, 3'b011, 32'h0, s);
    idle(2);

    // Load hitting a just-queued store
    do_store(32'h40, 32'hDEAD_BEEF, 3'b010, s);
    do_load("hit_lw", 32'h40, 3'b010, 32'hDEAD_BEEF, s);
    check_eq("hit_stall", 32'(s), 32'(HIT_STALL));
    do_load("addr_wrap", 32'h0000_1040, 3'b010, 32'hDEAD_BEEF, s);
    idle(2);

    // Mixed random traffic against the model
    for (int w = 0; w < 16; w++) do_store(32'h100 + 32'(4*w), $urandom, 3'b010, s);
    idle(10);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          sz = $urandom_range(0, 2);
          a  = 32'h100 + 32'(4*$urandom_range(0, 15));
          if (sz == 0) a = a + 32'($urandom_range(0, 3));
          if (sz == 1) a = a + 32'(2*$urandom_range(0, 1));
          do_store(a, $urandom, 3'(sz), s);
        end
        2: begin
          f3 = f3tab[$urandom_range(0, 4)];
          a  = 32'h100 + 32'(4*$urandom_range(0, 15));
          if (f3[1:0] == 2'b00) a = a + 32'($urandom_range(0, 3));
          if (f3[1:0] == 2'b01) a = a + 32'(2*$urandom_range(0, 1));
          do_load("rand_ld", a, f3, model_load(a, f3), s);
        end
        default: idle($urandom_range(1, 2));
      endcase
    end
    idle(8);

    // Reset discards pending stores
    do_store(32'h70, 32'h7070_7070, 3'b010, s);
    do_store(32'h74, 32'h7474_7474, 3'b010, s);
    do_store(32'h78, 32'h7878_7878, 3'b010, s);
    idle(8);
    do_store(32'h70, 32'h1111_1111, 3'b010, s);
    do_store(32'h74, 32'h2222_2222, 3'b010, s);
    do_store(32'h78, 32'h3333_3333, 3'b010, s);
    MemWriteM = 1'b0; reset = 1'b0;
    MemReadM = 1'b1; Mem_WrAddr = 32'h70; funct3M = 3'b010;
    @(negedge clk);
    check_eq("rst2_rdata", ReadData, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; MemReadM = 1'b0;
    check_eq("rst2_sb_empty", 32'(sb_empty), 32'd1);
    check_eq("rst2_err", 32'(err_sticky), 32'd0);
    do_load("rst_keep70", 32'h70, 3'b010, 32'h7070_7070, s);
    do_load("rst_keep74", 32'h74, 3'b010, 32'h7474_7474, s);
    do_load("rst_keep78", 32'h78, 3'b010, 32'h7878_7878, s);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
